// File: rtl/bp_pkg.sv
// Shared types and sizing helpers for the bimodal branch predictor and its BTB.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package bp_pkg;

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Tag is held zero-extended to DATA_WIDTH so the struct needs no ENTRIES parameter.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] tag;
        logic [DATA_WIDTH-1:0] target;
        ctr_e                  ctr;
    } bp_entry_t;

    function automatic int unsigned idx_width(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_width(input int unsigned entries);
        return DATA_WIDTH - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
interface branch_predictor_if;
    import bp_pkg::*;

    logic [DATA_WIDTH-1:0] pred_pc_i;
    logic                  pred_taken_o;
    logic [DATA_WIDTH-1:0] pred_target_o;
    logic                  upd_valid_i;
    logic [DATA_WIDTH-1:0] upd_pc_i;
    logic                  upd_taken_i;
    logic [DATA_WIDTH-1:0] upd_target_i;
    logic                  upd_pred_taken_i;
    logic [DATA_WIDTH-1:0] upd_pred_target_i;
    logic                  mispredict_o;
    logic [31:0]           br_cnt_o;
    logic [31:0]           mispred_cnt_o;

    modport master (
        output pred_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        input  pred_taken_o, pred_target_o, mispredict_o, br_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pred_pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
               upd_pred_taken_i, upd_pred_target_i,
        output pred_taken_o, pred_target_o, mispredict_o, br_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        unique case (i_ctr)
            SNT:     o_ctr = i_taken ? WNT : SNT;
            WNT:     o_ctr = i_taken ? WT  : SNT;
            WT:      o_ctr = i_taken ? ST  : WNT;
            ST:      o_ctr = i_taken ? ST  : WT;
            default: o_ctr = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with BTB: same-cycle lookup, trained by resolved branches.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bus
);

    localparam int unsigned IDX = idx_width(ENTRIES);
    localparam int unsigned TAG = tag_width(ENTRIES);

    bp_entry_t   r_table [ENTRIES];
    logic [31:0] r_br_cnt;
    logic [31:0] r_mispred_cnt;

    logic [IDX-1:0]        w_pred_idx;
    logic [IDX-1:0]        w_upd_idx;
    logic [DATA_WIDTH-1:0] w_pred_tag;
    logic [DATA_WIDTH-1:0] w_upd_tag;
    bp_entry_t             w_pred_e;
    bp_entry_t             w_upd_e;
    logic                  w_pred_hit;
    logic                  w_upd_hit;
    logic                  w_mispredict;
    ctr_e                  w_upd_ctr_next;

    assign w_pred_idx = bus.pred_pc_i[IDX+1:2];
    assign w_upd_idx  = bus.upd_pc_i[IDX+1:2];
    assign w_pred_tag = {{(DATA_WIDTH-TAG){1'b0}}, bus.pred_pc_i[DATA_WIDTH-1:IDX+2]};
    assign w_upd_tag  = {{(DATA_WIDTH-TAG){1'b0}}, bus.upd_pc_i[DATA_WIDTH-1:IDX+2]};

    assign w_pred_e   = r_table[w_pred_idx];
    assign w_upd_e    = r_table[w_upd_idx];
    assign w_pred_hit = w_pred_e.valid && (w_pred_e.tag == w_pred_tag);
    assign w_upd_hit  = w_upd_e.valid && (w_upd_e.tag == w_upd_tag);

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        bus.pred_taken_o  = w_pred_hit && w_pred_e.ctr[1];
        bus.pred_target_o = bus.pred_taken_o ? w_pred_e.target : '0;
    end

    always_comb begin
        w_mispredict = 1'b0;
        if (bus.upd_valid_i) begin
            w_mispredict = (bus.upd_taken_i != bus.upd_pred_taken_i) ||
                           (bus.upd_taken_i && bus.upd_pred_taken_i &&
                            (bus.upd_target_i != bus.upd_pred_target_i));
        end
    end

    assign bus.mispredict_o  = w_mispredict;
    assign bus.br_cnt_o      = r_br_cnt;
    assign bus.mispred_cnt_o = r_mispred_cnt;

    bp_sat_ctr u_sat_ctr (
        .i_ctr   (w_upd_e.ctr),
        .i_taken (bus.upd_taken_i),
        .o_ctr   (w_upd_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (bus.upd_valid_i) begin
            if (w_upd_hit) begin
                r_table[w_upd_idx].ctr <= w_upd_ctr_next;
                if (bus.upd_taken_i) begin
                    r_table[w_upd_idx].target <= bus.upd_target_i;
                end
            end else if (bus.upd_taken_i) begin
                // Taken miss evicts whatever aliased entry lives at this index.
                r_table[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag,
                                        target: bus.upd_target_i, ctr: WT};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_br_cnt      <= '0;
            r_mispred_cnt <= '0;
        end else if (bus.upd_valid_i) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16): one task per scenario, inline checks.
module tb_branch_predictor;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        bus.upd_valid_i       = v;
        bus.upd_pc_i          = pc;
        bus.upd_taken_i       = t;
        bus.upd_target_i      = tgt;
        bus.upd_pred_taken_i  = pt;
        bus.upd_pred_target_i = ptgt;
    endtask

    // Advance past one rising edge, drop the update strobe, let outputs settle.
    task automatic next_cycle();
        @(negedge clk);
        bus.upd_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.pred_pc_i = 32'h100;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.pred_taken_o !== 1'b0) begin errors++;
            $display("FAIL reset_taken: got %0b want 0", bus.pred_taken_o); end
        checks++; if (bus.pred_target_o !== 32'h0) begin errors++;
            $display("FAIL reset_target: got %h want 0", bus.pred_target_o); end
        checks++; if (bus.br_cnt_o !== 32'h0) begin errors++;
            $display("FAIL reset_br_cnt: got %0d want 0", bus.br_cnt_o); end
        checks++; if (bus.mispred_cnt_o !== 32'h0) begin errors++;
            $display("FAIL reset_mp_cnt: got %0d want 0", bus.mispred_cnt_o); end
        checks++; if (bus.mispredict_o !== 1'b0) begin errors++;
            $display("FAIL reset_mispredict: got %0b want 0", bus.mispredict_o); end
    endtask

    task automatic test_allocate();
        bus.pred_pc_i = 32'h100;
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        checks++; if (bus.mispredict_o !== 1'b1) begin errors++;
            $display("FAIL alloc_mispredict: got %0b want 1", bus.mispredict_o); end
        checks++; if (bus.pred_taken_o !== 1'b0) begin errors++;
            $display("FAIL alloc_no_bypass: got %0b want 0", bus.pred_taken_o); end
        next_cycle();
        checks++; if (bus.pred_taken_o !== 1'b1) begin errors++;
            $display("FAIL alloc_taken: got %0b want 1", bus.pred_taken_o); end
        checks++; if (bus.pred_target_o !== 32'h80) begin errors++;
            $display("FAIL alloc_target: got %h want 80", bus.pred_target_o); end
        checks++; if (bus.br_cnt_o !== 32'd1) begin errors++;
            $display("FAIL alloc_br_cnt: got %0d want 1", bus.br_cnt_o); end
        checks++; if (bus.mispred_cnt_o !== 32'd1) begin errors++;
            $display("FAIL alloc_mp_cnt: got %0d want 1", bus.mispred_cnt_o); end
        checks++; if (bus.mispredict_o !== 1'b0) begin errors++;
            $display("FAIL idle_mispredict: got %0b want 0", bus.mispredict_o); end
    endtask

    // Entry at 0x100 starts in WT; walk it down to SNT and back up.
    task automatic test_counter();
        logic exp_taken [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic upd_taken [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic prd_taken [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.pred_pc_i = 32'h100;
        for (int i = 0; i < 6; i++) begin
            set_upd(1'b1, 32'h100, upd_taken[i], 32'h80, prd_taken[i],
                    prd_taken[i] ? 32'h80 : 32'h0);
            next_cycle();
            checks++; if (bus.pred_taken_o !== exp_taken[i]) begin errors++;
                $display("FAIL ctr_step%0d: got %0b want %0b", i, bus.pred_taken_o,
                         exp_taken[i]); end
        end
        checks++; if (bus.pred_target_o !== 32'h80) begin errors++;
            $display("FAIL ctr_target: got %h want 80", bus.pred_target_o); end
        checks++; if (bus.br_cnt_o !== 32'd7) begin errors++;
            $display("FAIL ctr_br_cnt: got %0d want 7", bus.br_cnt_o); end
        checks++; if (bus.mispred_cnt_o !== 32'd4) begin errors++;
            $display("FAIL ctr_mp_cnt: got %0d want 4", bus.mispred_cnt_o); end
    endtask

    // 0x100 and 0x140 share index 0 with tags 4 and 5.
    task automatic test_alias();
        set_upd(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
        next_cycle();
        bus.pred_pc_i = 32'h100;
        #1;
        checks++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h0) begin errors++;
            $display("FAIL alias_old: got %0b/%h want 0/0", bus.pred_taken_o,
                     bus.pred_target_o); end
        bus.pred_pc_i = 32'h140;
        #1;
        checks++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h200) begin
            errors++;
            $display("FAIL alias_new: got %0b/%h want 1/200", bus.pred_taken_o,
                     bus.pred_target_o); end
    endtask

    task automatic test_target();
        bus.pred_pc_i = 32'h204;
        set_upd(1'b1, 32'h204, 1'b1, 32'h80, 1'b0, 32'h0);
        next_cycle();
        set_upd(1'b1, 32'h204, 1'b1, 32'h90, 1'b1, 32'h80);
        #1;
        checks++; if (bus.mispredict_o !== 1'b1) begin errors++;
            $display("FAIL tgt_mispredict: got %0b want 1", bus.mispredict_o); end
        next_cycle();
        bus.pred_pc_i = 32'h206;
        #1;
        checks++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h90) begin
            errors++;
            $display("FAIL tgt_update: got %0b/%h want 1/90", bus.pred_taken_o,
                     bus.pred_target_o); end
        set_upd(1'b1, 32'h204, 1'b1, 32'h90, 1'b1, 32'h90);
        #1;
        checks++; if (bus.mispredict_o !== 1'b0) begin errors++;
            $display("FAIL tgt_correct: got %0b want 0", bus.mispredict_o); end
        next_cycle();
        bus.pred_pc_i = 32'h308;
        set_upd(1'b1, 32'h308, 1'b0, 32'h40, 1'b0, 32'h0);
        #1;
        checks++; if (bus.mispredict_o !== 1'b0) begin errors++;
            $display("FAIL nt_mispredict: got %0b want 0", bus.mispredict_o); end
        next_cycle();
        checks++; if (bus.pred_taken_o !== 1'b0) begin errors++;
            $display("FAIL nt_no_alloc: got %0b want 0", bus.pred_taken_o); end
        checks++; if (bus.br_cnt_o !== 32'd12) begin errors++;
            $display("FAIL tgt_br_cnt: got %0d want 12", bus.br_cnt_o); end
        checks++; if (bus.mispred_cnt_o !== 32'd7) begin errors++;
            $display("FAIL tgt_mp_cnt: got %0d want 7", bus.mispred_cnt_o); end
    endtask

    task automatic test_reset_update();
        rst_n = 1'b0;
        set_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.upd_valid_i = 1'b0;
        bus.pred_pc_i = 32'h204;
        #1;
        checks++; if (bus.pred_taken_o !== 1'b0) begin errors++;
            $display("FAIL rst_table: got %0b want 0", bus.pred_taken_o); end
        bus.pred_pc_i = 32'h100;
        #1;
        checks++; if (bus.pred_taken_o !== 1'b0) begin errors++;
            $display("FAIL rst_drop_upd: got %0b want 0", bus.pred_taken_o); end
        checks++; if (bus.br_cnt_o !== 32'h0) begin errors++;
            $display("FAIL rst_br_cnt: got %0d want 0", bus.br_cnt_o); end
        checks++; if (bus.mispred_cnt_o !== 32'h0) begin errors++;
            $display("FAIL rst_mp_cnt: got %0d want 0", bus.mispred_cnt_o); end
    endtask

    task automatic test_wrap();
        force dut.r_br_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_br_cnt;
        set_upd(1'b1, 32'h308, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        checks++; if (bus.br_cnt_o !== 32'h0) begin errors++;
            $display("FAIL wrap_br_cnt: got %h want 0", bus.br_cnt_o); end
        checks++; if (bus.mispred_cnt_o !== 32'h0) begin errors++;
            $display("FAIL wrap_mp_cnt: got %h want 0", bus.mispred_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_target();
        test_reset_update();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch predictor (2-bit bimodal history plus branch target buffer) for the RV32I fetch path. It returns a same-cycle taken/target prediction for the fetch PC. It is trained by the branch comparator's resolved outcome for conditional branches. It also flags mispredicts and keeps branch and mispredict event counters.

## Interface
- `ENTRIES`, 16: number of table entries; power of two, ≥2. IDX = log2(ENTRIES).
- `DATA_WIDTH`, 32 (global `` `DATA_WIDTH ``): PC/target width.

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `pred_pc_i`  in  DATA_WIDTH  fetch PC to predict
- `pred_taken_o`  out  1  predicted taken
- `pred_target_o`  out  DATA_WIDTH  predicted target; 0 when `pred_taken_o`=0
- `upd_valid_i`  in  1  one resolved conditional branch this cycle
- `upd_pc_i`  in  DATA_WIDTH  PC of resolved branch
- `upd_taken_i`  in  1  comparator result (branch flag)
- `upd_target_i`  in  DATA_WIDTH  computed branch target
- `upd_pred_taken_i`  in  1  prediction made for this branch at fetch
- `upd_pred_target_i`  in  DATA_WIDTH  target predicted at fetch
- `mispredict_o`  out  1  resolved outcome disagrees with prediction
- `br_cnt_o`  out  32  resolved-branch count
- `mispred_cnt_o`  out  32  mispredict count

## Operation
- Index = pc[IDX+1:2]; tag = pc[DATA_WIDTH-1:IDX+2]; pc[1:0] ignored.
- Entry: valid (1), tag, target (DATA_WIDTH), ctr (2-bit).
- Lookup (combinational from registered table): hit = valid & tag match. `pred_taken_o` = hit & ctr[1]; `pred_target_o` = target if `pred_taken_o`, else 0.
- Counter FSM, per entry: SNT(00) ↔ WNT(01) ↔ WT(10) ↔ ST(11).
  - Taken increments, saturating at ST.
  - Not-taken decrements, saturating at SNT.
- Update when `upd_valid_i`=1:
  - Hit: step ctr by `upd_taken_i`. If taken, overwrite target with `upd_target_i`.
  - Miss and taken: allocate/replace. Set valid=1, tag, target, ctr=WT.
  - Miss and not-taken: no change.
- `mispredict_o` = `upd_valid_i` & ((`upd_taken_i` ≠ `upd_pred_taken_i`) | (`upd_taken_i` & `upd_pred_taken_i` & `upd_target_i` ≠ `upd_pred_target_i`)). Combinational; 0 when `upd_valid_i`=0.
- `br_cnt_o` increments on every `upd_valid_i`. `mispred_cnt_o` increments when `mispredict_o`=1. Both wrap 0xFFFF_FFFF → 0.

## Timing
- Lookup latency 0 cycles; update visible from the edge following `upd_valid_i`.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
- Reset (`rst_n`=0 at an edge):
  - All valid=0, ctr=WNT, tag=0, target=0, both counters=0.
  - Reset wins over a concurrent update; that update is dropped and not counted.
- Outputs after reset: `pred_taken_o`=0, `pred_target_o`=0, `br_cnt_o`=0, `mispred_cnt_o`=0. `mispredict_o` follows its inputs combinationally.
- Aliasing: a tag mismatch on a taken branch evicts the prior entry unconditionally.

## Structure
- Shared package `bp_pkg`: ctr state constants (SNT/WNT/WT/ST), `bp_entry_t` struct (valid, tag, target, ctr), index/tag width functions of ENTRIES.
- One sub-module `bp_sat_ctr`: 2-bit saturating next-state logic (ctr, taken → next ctr), combinational, instantiated once for the update index.

## Test plan
- Reset, then lookup pc=0x100: `pred_taken_o`=0, `pred_target_o`=0, counters=0.
- Update pc=0x100 taken target 0x80, predicted not-taken: `mispredict_o`=1; next cycle lookup 0x100 gives taken/0x80; `br_cnt_o`=1, `mispred_cnt_o`=1.
- Three not-taken updates to 0x100 from WT: after the first, prediction is not-taken; ctr saturates at SNT; a fourth not-taken leaves it SNT; two taken updates are needed to predict taken again.
- ENTRIES=16: taken branch at 0x100, then taken at 0x140 (same index, different tag): lookup 0x100 misses, lookup 0x140 predicts taken.
- Predicted taken to 0x80, actual taken to 0x90: `mispredict_o`=1; the entry target becomes 0x90.
- `rst_n`=0 concurrent with `upd_valid_i`=1: next cycle table empty and `br_cnt_o`=0. Force `br_cnt_o`=0xFFFF_FFFF, then one update: `br_cnt_o`=0.
